fetch_unit: RTL and testbench

Instruction fetch stage for the E10 RV32 core. Generates word-aligned instruction addresses, runs a single-outstanding request/response handshake with instruction memory, and buffers returned words with their PCs in a small FIFO. The FIFO drives `decode` through a valid/ready interface. A redirect from decode/branch logic flushes the buffer and discards any in-flight response.

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 59 +++++
 rtl/fetch_unit.sv | 157 +++++++++++++++
 tb/tb_fetch_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants: NOP encoding, fetch FSM state encodings,
// the buffered entry layout and a PC alignment helper.
package fetch_unit_pkg;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  localparam logic [1:0] ST_IDLE = 2'd0;  // no request outstanding
  localparam logic [1:0] ST_REQ  = 2'd1;  // request raised, waiting for grant
  localparam logic [1:0] ST_WAIT = 2'd2;  // granted, waiting for response
  localparam logic [1:0] ST_DROP = 2'd3;  // granted, response will be discarded

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: circular FIFO with wrap-bit pointers. Flush wins over
// push and pop. A push while full is only accepted together with a pop.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign count_o = wr_ptr - rd_ptr;
  assign full_o  = (count_o == DEPTH_C);
  assign empty_o = (wr_ptr == rd_ptr);
  assign data_o  = mem[rd_ptr[AW-1:0]];

  assign do_push = push_i && (!full_o || pop_i) && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // Pointer update; flush returns both pointers to the origin.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty gates the outputs.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= data_i;
  end

  // Slot reservation upstream must make an unpaired push into a full FIFO impossible.
  assert property (@(posedge clk_i) disable iff (!rst_i)
    !(push_i && full_o && !pop_i && !flush_i));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding request/response to imem,
// responses buffered with their PCs and offered to decode.
// Handshake: decode consumes the head at a rising edge where instr_valid_o and
// instr_ready_i are both high; imem accepts a request at an edge where
// imem_req_o and imem_gnt_i are both high, and a raised request holds its
// address until then.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  output logic [1:0]  state_o
);

  import fetch_unit_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = FIFO_DEPTH[CW-1:0];
  localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   gnt_pc_q, gnt_pc_d;
  logic          drop_pend_q, drop_pend_d;
  logic          req_q;

  logic [31:0]   redirect_pc;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_after;
  logic          slot_left;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;

  assign redirect_pc = align_pc(redirect_pc_i);
  assign fifo_pop    = !fifo_empty && instr_ready_i && !redirect_i;
  assign fifo_push   = (state_q == ST_WAIT) && imem_rvalid_i && !redirect_i;
  assign count_after = fifo_count + ONE_C - {{(CW-1){1'b0}}, fifo_pop};
  assign slot_left   = (count_after < DEPTH_C);
  assign push_entry  = '{pc: gnt_pc_q, instr: imem_rdata_i};

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (push_entry),
    .pop_i   (fifo_pop),
    .flush_i (redirect_i),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Next-state logic: a redirect always retargets fetch_pc; a raised request
  // is never withdrawn, so a redirect in REQ is remembered and its grant drops.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    addr_d      = addr_q;
    gnt_pc_d    = gnt_pc_q;
    drop_pend_d = drop_pend_q;
    if (redirect_i) fetch_pc_d = redirect_pc;
    case (state_q)
      ST_IDLE: begin
        if (redirect_i) begin
          state_d = ST_REQ;
          addr_d  = redirect_pc;
        end else if (fifo_count < DEPTH_C) begin
          state_d = ST_REQ;
          addr_d  = fetch_pc_q;
        end
      end
      ST_REQ: begin
        if (redirect_i) drop_pend_d = 1'b1;
        if (imem_gnt_i) begin
          gnt_pc_d    = addr_q;
          drop_pend_d = 1'b0;
          if (redirect_i || drop_pend_q) begin
            state_d = ST_DROP;
          end else begin
            state_d    = ST_WAIT;
            fetch_pc_d = addr_q + 32'd4;
          end
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          if (redirect_i) begin
            state_d = ST_REQ;
            addr_d  = redirect_pc;
          end else if (slot_left) begin
            state_d = ST_REQ;
            addr_d  = fetch_pc_q;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (redirect_i) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (imem_rvalid_i) begin
          state_d = ST_REQ;
          addr_d  = redirect_i ? redirect_pc : fetch_pc_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and address registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      fetch_pc_q  <= RESET_PC;
      addr_q      <= RESET_PC;
      gnt_pc_q    <= 32'd0;
      drop_pend_q <= 1'b0;
      req_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      addr_q      <= addr_d;
      gnt_pc_q    <= gnt_pc_d;
      drop_pend_q <= drop_pend_d;
      req_q       <= (state_d == ST_REQ);
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = addr_q;
  assign instr_valid_o = !fifo_empty;
  assign instr_o       = fifo_empty ? INSTR_NOP : head_entry.instr;
  assign instr_pc_o    = fifo_empty ? 32'd0 : head_entry.pc;
  assign state_o       = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with a hand-driven memory, then a
// randomized phase with an automatic memory responder. Expected words are
// queued by the stimulus side; a negedge monitor pops and compares them.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC   = 32'h0000_0100;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam logic [31:0] BAD_WORD = 32'hDEAD_BEEF;

  logic        clk_i;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  logic [1:0]  state_o;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_consumed = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_next_pc;
  bit          auto_exp = 0;
  bit          mem_auto = 0;
  bit          mem_fast = 0;
  bit          mem_pend = 0;
  logic [31:0] mem_pend_addr;
  int          mem_lat;
  logic [31:0] salt;

  fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i),
    .state_o       (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, got no end, expected end");
    $fatal(1, "timeout");
  end

  // ---------------- reference helpers ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ salt;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back({exp_next_pc, mem_word(exp_next_pc)});
      exp_next_pc = exp_next_pc + 32'd4;
    end
  endtask

  // ---------------- memory model (automatic mode) ----------------
  task automatic mem_sample();
    if (imem_req_o && imem_gnt_i) begin
      mem_pend      = 1'b1;
      mem_pend_addr = imem_addr_o;
      mem_lat       = mem_fast ? 0 : $urandom_range(0, 2);
    end
  endtask

  task automatic mem_drive();
    imem_gnt_i = mem_fast ? 1'b1 : ($urandom_range(0, 3) != 0);
    if (mem_pend && mem_lat == 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(mem_pend_addr);
      mem_pend      = 1'b0;
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
      if (mem_pend) mem_lat--;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one cycle; returns 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk_i);
    if (mem_auto) mem_sample();
    @(posedge clk_i);
    #1;
    redirect_i = 1'b0;
    if (mem_auto) mem_drive();
    else begin
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
    end
    if (auto_exp) refill();
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_i    = 1'b1;
    redirect_pc_i = pc;
    exp_q.delete();
    exp_next_pc = {pc[31:2], 2'b00};
    if (auto_exp) refill();
  endtask

  task automatic wait_req(input int max, input string name);
    int k;
    k = 0;
    while (!imem_req_o && k < max) begin
      tick();
      k++;
    end
    check(name, imem_req_o, 1);
  endtask

  task automatic serve(input logic [31:0] data);
    wait_req(8, "serve_req");
    imem_gnt_i = 1'b1;
    tick();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = data;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   imem_req_o,    0);
    check({tag, "_addr"},  imem_addr_o,   RST_PC);
    check({tag, "_valid"}, instr_valid_o, 0);
    check({tag, "_instr"}, instr_o,       NOP_WORD);
    check({tag, "_pc"},    instr_pc_o,    0);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic        prev_rst = 1'b0, prev_redirect = 1'b0, prev_req = 1'b0, prev_gnt = 1'b0;
  logic        prev_valid = 1'b0, prev_pop = 1'b0;
  logic [31:0] prev_addr, prev_instr, prev_pc;

  // Pops one expected entry per consumed word and checks interface invariants.
  always @(negedge clk_i) begin
    logic [63:0] e;
    if (rst_i) begin
      if (instr_valid_o && instr_ready_i && !redirect_i) begin
        n_consumed++;
        if (exp_q.size() == 0) begin
          check("consume_unexpected", {instr_pc_o, instr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("consume", {instr_pc_o, instr_o}, e);
        end
      end
      if (!instr_valid_o) check("empty_outputs", {instr_pc_o, instr_o}, {32'd0, NOP_WORD});
      if (imem_req_o) check("addr_aligned", imem_addr_o[1:0], 0);
      if (prev_rst) begin
        if (prev_redirect) check("redirect_flush", instr_valid_o, 0);
        if (prev_req && !prev_gnt) check("req_hold", {imem_req_o, imem_addr_o}, {1'b1, prev_addr});
        if (prev_valid && !prev_pop && !prev_redirect)
          check("head_stable", {instr_pc_o, instr_o}, {prev_pc, prev_instr});
      end
    end
    prev_rst      = rst_i;
    prev_redirect = redirect_i;
    prev_req      = imem_req_o;
    prev_gnt      = imem_gnt_i;
    prev_addr     = imem_addr_o;
    prev_valid    = instr_valid_o;
    prev_pop      = instr_valid_o && instr_ready_i && !redirect_i;
    prev_instr    = instr_o;
    prev_pc       = instr_pc_o;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] w1, w2, w3, w4, w5;
    salt          = $urandom;
    rst_i         = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'd0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'd0;
    instr_ready_i = 1'b0;
    w1 = 32'h0010_0113;
    w2 = 32'h00A0_0113;
    w3 = 32'h0030_0193;
    w4 = 32'h0040_0213;
    w5 = 32'h0050_0293;

    repeat (3) @(posedge clk_i);
    #1;
    check_reset_outputs("reset");

    // First fetch at RESET_PC, word visible in cycle 3.
    rst_i = 1'b1;
    check("first_req_idle", imem_req_o, 0);
    tick();
    check("first_req", {imem_req_o, imem_addr_o}, {1'b1, RST_PC});
    exp_q.push_back({RST_PC, 32'h0050_0093});
    imem_gnt_i = 1'b1;
    tick();
    check("wait_no_req", imem_req_o, 0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h0050_0093;
    tick();
    check("first_word", {instr_valid_o, instr_pc_o, instr_o}, {1'b1, RST_PC, 32'h0050_0093});
    check("second_req", {imem_req_o, imem_addr_o}, {1'b1, RST_PC + 32'd4});

    // Fill the buffer with decode stalled: no further request.
    exp_q.push_back({RST_PC + 32'd4, w1});
    imem_gnt_i = 1'b1;
    tick();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = w1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("full_no_req", {instr_valid_o, imem_req_o}, {1'b1, 1'b0});
      tick();
    end
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    wait_req(4, "req_after_pop");
    check("req_after_pop_addr", imem_addr_o, RST_PC + 32'd8);

    // Redirect while waiting for the response: the late word is dropped.
    imem_gnt_i = 1'b1;
    tick();
    do_redirect(32'h0000_0200);
    exp_q.push_back({32'h0000_0200, w2});
    tick();
    check("wait_redirect_valid", instr_valid_o, 0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = BAD_WORD;
    tick();
    check("wait_redirect_req", {imem_req_o, imem_addr_o}, {1'b1, 32'h0000_0200});
    serve(w2);
    check("redirect_first_word", {instr_valid_o, instr_pc_o, instr_o}, {1'b1, 32'h0000_0200, w2});

    // Redirect together with rvalid and a pop.
    wait_req(6, "pre_same_cycle_req");
    imem_gnt_i = 1'b1;
    tick();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = BAD_WORD;
    instr_ready_i = 1'b1;
    do_redirect(32'h0000_0303);
    exp_q.push_back({32'h0000_0300, w3});
    tick();
    instr_ready_i = 1'b0;
    check("same_cycle_empty", instr_valid_o, 0);
    wait_req(4, "same_cycle_req");
    check("same_cycle_addr", imem_addr_o, 32'h0000_0300);

    // Redirect in REQ with a delayed grant: address held, response dropped.
    do_redirect(32'h0000_0400);
    exp_q.push_back({32'h0000_0400, w4});
    for (int i = 0; i < 3; i++) begin
      tick();
      check("req_redirect_hold", {imem_req_o, imem_addr_o}, {1'b1, 32'h0000_0300});
    end
    imem_gnt_i = 1'b1;
    tick();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = BAD_WORD;
    tick();
    check("req_redirect_new", {imem_req_o, imem_addr_o}, {1'b1, 32'h0000_0400});
    instr_ready_i = 1'b1;
    serve(w4);
    tick();
    instr_ready_i = 1'b0;
    tick();
    check("directed_drained", exp_q.size(), 0);

    // Reset during WAIT, then a stale response right at release.
    wait_req(6, "pre_reset_req");
    imem_gnt_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    check_reset_outputs("midreset");
    tick();
    check_reset_outputs("midreset_hold");
    rst_i         = 1'b1;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = BAD_WORD;
    exp_q.delete();
    exp_q.push_back({RST_PC, w5});
    check("release_no_req", imem_req_o, 0);
    tick();
    check("restart_req", {imem_req_o, imem_addr_o, instr_valid_o}, {1'b1, RST_PC, 1'b0});
    instr_ready_i = 1'b1;
    serve(w5);
    tick();
    instr_ready_i = 1'b0;
    check("reset_drained", exp_q.size(), 0);

    // Randomized phase: automatic memory, random ready and redirects.
    mem_pend = 1'b0;
    mem_auto = 1'b1;
    auto_exp = 1'b1;
    tick();
    do_redirect(32'hFFFF_FFF9);
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (c % 500 == 250) mem_fast = !mem_fast;
      instr_ready_i = ($urandom_range(0, 3) != 0);
      if (c > 40 && $urandom_range(0, 29) == 0) begin
        if ($urandom_range(0, 1) == 0) do_redirect($urandom);
        else do_redirect($urandom_range(0, 4095));
      end
    end
    instr_ready_i = 1'b0;
    repeat (5) tick();
    check("progress", (n_consumed >= 200), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
